ladybird_axi_sram: RTL and testbench



---
 rtl/ladybird_axi_pkg.sv | 27 ++
 rtl/ladybird_axi_sram_addr_gen.sv | 47 ++++
 rtl/ladybird_axi_sram.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ladybird_axi_sram.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_axi_pkg.sv
// AXI4 encodings and FSM state types shared by the ladybird AXI SRAM responder.
package ladybird_axi;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] axi_burst_fixed    = 2'b00;
  localparam logic [BURST_W-1:0] axi_burst_incr     = 2'b01;
  localparam logic [BURST_W-1:0] axi_burst_wrap     = 2'b10;
  localparam logic [BURST_W-1:0] axi_burst_reserved = 2'b11;

  localparam logic [RESP_W-1:0] axi_resp_okay   = 2'b00;
  localparam logic [RESP_W-1:0] axi_resp_exokay = 2'b01;
  localparam logic [RESP_W-1:0] axi_resp_slverr = 2'b10;
  localparam logic [RESP_W-1:0] axi_resp_decerr = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ladybird_axi_sram_addr_gen.sv
// Combinational beat-address sequencer: next beat address and per-beat error flag.
module ladybird_axi_addr_gen
  import ladybird_axi::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BYTES  = 65536
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               err
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] span_mask;
  logic [ADDR_W-1:0] incr_addr;

  // Step, alignment and wrap-span masks; spans are powers of two whenever WRAP is legal.
  always_comb begin
    step      = ADDR_W'(1) << size;
    size_mask = step - ADDR_W'(1);
    incr_addr = (addr & ~size_mask) + step;
    span_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
  end

  // Select the next address by burst type and flag illegal beats.
  always_comb begin
    next_addr = addr;
    unique case (burst)
      axi_burst_fixed: next_addr = addr;
      axi_burst_incr:  next_addr = incr_addr;
      axi_burst_wrap:  next_addr = (addr & ~span_mask) | (incr_addr & span_mask);
      default:         next_addr = addr;
    endcase
    err = (size > SIZE_W'(OFF_W))
        | (burst == axi_burst_reserved)
        | ((burst == axi_burst_wrap) & ~wrap_len_ok(len))
        | (64'(addr) >= 64'(BYTES));
  end

endmodule

// File: rtl/ladybird_axi_sram.sv
// AXI4 responder over a 1R1W byte-enable memory; independent read and write FSMs.
module ladybird_axi_sram
  import ladybird_axi::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned BYTES  = 65536
) (
  input  logic                clk,
  input  logic                nrst,
  // Write address
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [SIZE_W-1:0]   awsize,
  input  logic [BURST_W-1:0]  awburst,
  input  logic                awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  // Write data
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  // Write response
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [RESP_W-1:0]   bresp,
  // Read address
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [SIZE_W-1:0]   arsize,
  input  logic [BURST_W-1:0]  arburst,
  input  logic                arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  // Read data
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [RESP_W-1:0]   rresp,
  output logic                rlast
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned MEM_AW = $clog2(BYTES);
  localparam int unsigned WORDS  = BYTES / STRB_W;
  localparam int unsigned IDX_W  = MEM_AW - OFF_W;

  // Lock, cache and protection attributes have no meaning for a plain SRAM.
  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  // ---------------------------------------------------------------- write side
  w_state_e           w_state;
  logic [ADDR_W-1:0]  w_addr_q;
  logic [LEN_W-1:0]   w_len_q;
  logic [SIZE_W-1:0]  w_size_q;
  logic [BURST_W-1:0] w_burst_q;
  logic [LEN_W:0]     w_beat_q;   // one extra bit so it can sit at len+1 for dropped beats
  logic               w_err_q;
  logic [ADDR_W-1:0]  w_next;
  logic               w_beat_err;
  logic               w_in_range;
  logic               w_err_next;
  logic               mem_we;
  logic [IDX_W-1:0]   w_idx;

  ladybird_axi_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYTES  (BYTES)
  ) u_w_addr_gen (
    .addr      (w_addr_q),
    .len       (w_len_q),
    .size      (w_size_q),
    .burst     (w_burst_q),
    .next_addr (w_next),
    .err       (w_beat_err)
  );

  // Decide whether the current W beat lands in memory and fold it into the response.
  always_comb begin
    w_in_range = (w_beat_q <= {1'b0, w_len_q});
    mem_we     = (w_state == W_DATA) & wvalid & w_in_range & ~w_beat_err;
    w_err_next = w_err_q
               | (w_in_range & w_beat_err)
               | (wlast & (w_beat_q != {1'b0, w_len_q}));
    w_idx      = w_addr_q[MEM_AW-1:OFF_W];
  end

  // Write FSM: accept AW, consume W beats, return B.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_state   <= W_IDLE;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= axi_resp_okay;
      bid       <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            bid       <= awid;
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (w_in_range) begin
              w_addr_q <= w_next;
              w_beat_q <= w_beat_q + 1'b1;
            end
            w_err_q <= w_err_next;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= w_err_next ? axi_resp_slverr : axi_resp_okay;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_e           r_state;
  logic [ADDR_W-1:0]  r_addr_q;
  logic [LEN_W-1:0]   r_len_q;
  logic [SIZE_W-1:0]  r_size_q;
  logic [BURST_W-1:0] r_burst_q;
  logic [LEN_W-1:0]   r_beat_q;
  logic               r_zero_q;   // current beat erred, so its data is forced to zero
  logic [ADDR_W-1:0]  r_next;
  logic               r_beat_err;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  mem_rd_q;

  ladybird_axi_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYTES  (BYTES)
  ) u_r_addr_gen (
    .addr      (r_addr_q),
    .len       (r_len_q),
    .size      (r_size_q),
    .burst     (r_burst_q),
    .next_addr (r_next),
    .err       (r_beat_err)
  );

  assign r_idx = r_addr_q[MEM_AW-1:OFF_W];
  assign rdata = (rvalid && !r_zero_q) ? mem_rd_q : '0;

  // Read FSM: accept AR, fetch one word per beat, hold R until accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= R_IDLE;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rresp     <= axi_resp_okay;
      rid       <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_zero_q  <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rid       <= arid;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_beat_q  <= '0;
            arready   <= 1'b0;
            r_state   <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid   <= 1'b1;
          rresp    <= r_beat_err ? axi_resp_slverr : axi_resp_okay;
          r_zero_q <= r_beat_err;
          rlast    <= (r_beat_q == r_len_q);
          r_state  <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr_q <= r_next;
              r_beat_q <= r_beat_q + 1'b1;
              r_state  <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------- memory
  logic [DATA_W-1:0] mem [WORDS];

  // Byte-enable write port; deliberately unreset so contents survive nrst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read port; a same-cycle write to the word is not yet visible.
  always_ff @(posedge clk) begin
    if (r_state == R_FETCH) mem_rd_q <= mem[r_idx];
  end

endmodule

// File: tb/tb_ladybird_axi_sram.sv
// Randomized self-checking bench for ladybird_axi_sram against a byte-array model.
module tb_ladybird_axi_sram;

  localparam int unsigned BYTES = 65536;

  logic        clk, nrst;
  logic        awvalid, awready, awlock;
  logic [3:0]  awid, awcache;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready, arlock;
  logic [3:0]  arid, arcache;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  ladybird_axi_sram #(
    .DATA_W (32),
    .ADDR_W (32),
    .ID_W   (4),
    .BYTES  (BYTES)
  ) dut (
    .clk     (clk),     .nrst    (nrst),
    .awvalid (awvalid), .awready (awready), .awid    (awid),    .awaddr  (awaddr),
    .awlen   (awlen),   .awsize  (awsize),  .awburst (awburst), .awlock  (awlock),
    .awcache (awcache), .awprot  (awprot),
    .wvalid  (wvalid),  .wready  (wready),  .wdata   (wdata),   .wstrb   (wstrb),
    .wlast   (wlast),
    .bvalid  (bvalid),  .bready  (bready),  .bid     (bid),     .bresp   (bresp),
    .arvalid (arvalid), .arready (arready), .arid    (arid),    .araddr  (araddr),
    .arlen   (arlen),   .arsize  (arsize),  .arburst (arburst), .arlock  (arlock),
    .arcache (arcache), .arprot  (arprot),
    .rvalid  (rvalid),  .rready  (rready),  .rid     (rid),     .rdata   (rdata),
    .rresp   (rresp),   .rlast   (rlast)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus / capture buffers
  logic [31:0] wd   [0:299];
  logic [3:0]  ws   [0:299];
  logic [31:0] rd_d [0:299];
  logic [1:0]  rd_r [0:299];
  logic        rd_l [0:299];
  int          rd_g [0:299];
  int          rd_n, rd_lat;
  logic [3:0]  rd_id;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;
  logic        wr_bimm;

  // Reference model
  logic [7:0]  mem_m [0:BYTES-1];
  longint      ba    [0:299];
  logic [31:0] ex_d  [0:299];
  logic [1:0]  ex_r  [0:299];

  function automatic bit burst_bad(input int len, input int size, input int burst);
    return size > 2 || burst == 3 ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic model_addrs(input longint addr, input int len, input int size, input int burst);
    longint a, step, span, base;
    step = longint'(1) << size;
    span = longint'(len + 1) * step;
    base = (addr / span) * span;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      ba[i] = a;
      if (burst == 1) a = (a / step) * step + step;
      else if (burst == 2) begin
        a = (a / step) * step + step;
        if (a >= base + span) a = base;
      end
    end
  endtask

  task automatic model_write(input longint addr, input int len, input int size, input int burst,
                             input int nbeats, output logic [1:0] resp);
    bit bad, any;
    bad = burst_bad(len, size, burst);
    any = (nbeats != len + 1);
    model_addrs(addr, len, size, burst);
    for (int i = 0; i < nbeats; i++) begin
      if (i <= len) begin
        if (bad || ba[i] >= BYTES) any = 1;
        else for (int b = 0; b < 4; b++)
          if (ws[i][b]) mem_m[int'((ba[i] / 4) * 4) + b] = wd[i][8*b +: 8];
      end
    end
    resp = any ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input longint addr, input int len, input int size, input int burst);
    bit bad;
    int w;
    bad = burst_bad(len, size, burst);
    model_addrs(addr, len, size, burst);
    for (int i = 0; i <= len; i++) begin
      if (bad || ba[i] >= BYTES) begin
        ex_d[i] = '0; ex_r[i] = 2'b10;
      end else begin
        w = int'((ba[i] / 4) * 4);
        ex_d[i] = {mem_m[w+3], mem_m[w+2], mem_m[w+1], mem_m[w]};
        ex_r[i] = 2'b00;
      end
    end
  endtask

  // Bus drivers
  task automatic do_write(input logic [3:0] id, input longint addr, input int len, input int size,
                          input int burst, input int nbeats);
    int t;
    @(negedge clk);
    awvalid = 1; awid = id; awaddr = 32'(addr); awlen = 8'(len);
    awsize = 3'(size); awburst = 2'(burst);
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_cmp++; n_fail++; $display("FAIL aw_timeout: awready stayed %b, want 1", awready); end
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin n_cmp++; n_fail++; $display("FAIL w_timeout: wready stayed %b, want 1", wready); end
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    wr_bimm = bvalid;
    bready = 1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_cmp++; n_fail++; $display("FAIL b_timeout: bvalid stayed %b, want 1", bvalid); end
    wr_resp = bresp; wr_id = bid;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input longint addr, input int len, input int size,
                         input int burst);
    int t, gap;
    bit done;
    @(negedge clk);
    arvalid = 1; arid = id; araddr = 32'(addr); arlen = 8'(len);
    arsize = 3'(size); arburst = 2'(burst);
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_cmp++; n_fail++; $display("FAIL ar_timeout: arready stayed %b, want 1", arready); end
    @(negedge clk);
    arvalid = 0;
    rready = 1;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clk); t++; end
    rd_lat = t + 1;
    rd_n = 0; gap = 0; done = 0;
    while (!done && rd_n < 300) begin
      if (rvalid) begin
        rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; rd_g[rd_n] = gap;
        rd_id = rid; done = rlast; rd_n++;
        @(negedge clk); gap = 1;
      end else begin
        @(negedge clk); gap++;
        if (gap > 50) begin
          n_cmp++; n_fail++; $display("FAIL r_timeout: rvalid stayed %b, want 1", rvalid);
          done = 1;
        end
      end
    end
    rready = 0;
  endtask

  // ----------------------------------------------------------------- scenarios
  task automatic test_reset();
    nrst = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (awready !== 1'b1) begin n_fail++; $display("FAIL rst_awready: got %b want 1", awready); end
    n_cmp++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready: got %b want 1", arready); end
    n_cmp++; if ({wready, bvalid, rvalid, rlast} !== 4'b0)
      begin n_fail++; $display("FAIL rst_valids: got %b want 0000", {wready, bvalid, rvalid, rlast}); end
    n_cmp++; if ({bresp, rresp, bid, rid} !== 12'h0)
      begin n_fail++; $display("FAIL rst_resp_ids: got %h want 000", {bresp, rresp, bid, rid}); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    nrst = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [1:0] er;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'd5, 'h100, 0, 2, 1, 1);
    model_write('h100, 0, 2, 1, 1, er);
    n_cmp++; if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL single_bresp: got %b want 00", wr_resp); end
    n_cmp++; if (wr_id !== 4'd5) begin n_fail++; $display("FAIL single_bid: got %0d want 5", wr_id); end
    n_cmp++; if (wr_bimm !== 1'b1) begin n_fail++; $display("FAIL single_b_latency: bvalid %b after wlast, want 1", wr_bimm); end
    do_read(4'd9, 'h100, 0, 2, 1);
    n_cmp++; if (rd_n !== 1) begin n_fail++; $display("FAIL single_beats: got %0d want 1", rd_n); end
    n_cmp++; if (rd_d[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", rd_d[0]); end
    n_cmp++; if (rd_r[0] !== 2'b00 || rd_l[0] !== 1'b1)
      begin n_fail++; $display("FAIL single_rresp_rlast: got %b/%b want 00/1", rd_r[0], rd_l[0]); end
    n_cmp++; if (rd_id !== 4'd9) begin n_fail++; $display("FAIL single_rid: got %0d want 9", rd_id); end
    n_cmp++; if (rd_lat !== 2) begin n_fail++; $display("FAIL single_r_latency: got %0d want 2", rd_lat); end
  endtask

  task automatic test_incr4();
    logic [1:0] er;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'd1, 'h200, 3, 2, 1, 4);
    model_write('h200, 3, 2, 1, 4, er);
    n_cmp++; if (wr_resp !== er) begin n_fail++; $display("FAIL incr4_bresp: got %b want %b", wr_resp, er); end
    do_read(4'd2, 'h200, 3, 2, 1);
    n_cmp++; if (rd_n !== 4) begin n_fail++; $display("FAIL incr4_beats: got %0d want 4", rd_n); end
    for (int i = 0; i < 4 && i < rd_n; i++) begin
      n_cmp++; if (rd_d[i] !== 32'(i + 1) || rd_l[i] !== (i == 3))
        begin n_fail++; $display("FAIL incr4_beat%0d: got %h/last %b want %h/last %b", i, rd_d[i], rd_l[i], i + 1, i == 3); end
      if (i > 0) begin
        n_cmp++; if (rd_g[i] !== 2) begin n_fail++; $display("FAIL incr4_gap%0d: got %0d want 2", i, rd_g[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] er;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd3, 'h208, 3, 2, 2, 4);
    model_write('h208, 3, 2, 2, 4, er);
    n_cmp++; if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL wrap_bresp: got %b want 00", wr_resp); end
    // Beats went to 0x208, 0x20C, 0x200, 0x204, so a linear read sees A2 A3 A0 A1.
    do_read(4'd3, 'h200, 3, 2, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_d[i] !== 32'hA0 + 32'((i + 2) % 4))
        begin n_fail++; $display("FAIL wrap_linear%0d: got %h want %h", i, rd_d[i], 32'hA0 + 32'((i + 2) % 4)); end
    end
    do_read(4'd4, 'h208, 3, 2, 2);
    model_read('h208, 3, 2, 2);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_d[i] !== ex_d[i]) begin n_fail++; $display("FAIL wrap_read%0d: got %h want %h", i, rd_d[i], ex_d[i]); end
    end
  endtask

  task automatic test_narrow();
    logic [1:0] er;
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'd0, 'h300, 0, 2, 1, 1);
    model_write('h300, 0, 2, 1, 1, er);
    wd[0] = 32'h0000AB00; ws[0] = 4'b0010;
    do_write(4'd0, 'h301, 0, 0, 1, 1);
    model_write('h301, 0, 0, 1, 1, er);
    do_read(4'd0, 'h300, 0, 2, 1);
    n_cmp++; if (rd_d[0] !== 32'h1122AB44) begin n_fail++; $display("FAIL narrow_rdata: got %h want 1122ab44", rd_d[0]); end
  endtask

  task automatic test_errors();
    logic [1:0] er;
    do_read(4'd6, longint'(BYTES), 0, 2, 1);
    n_cmp++; if (rd_r[0] !== 2'b10 || rd_d[0] !== 32'h0)
      begin n_fail++; $display("FAIL oob_read: got resp %b data %h want 10/0", rd_r[0], rd_d[0]); end
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(4'd7, 'h300, 0, 3, 1, 1);
    model_write('h300, 0, 3, 1, 1, er);
    n_cmp++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL size3_bresp: got %b want 10", wr_resp); end
    do_read(4'd0, 'h300, 0, 2, 1);
    n_cmp++; if (rd_d[0] !== 32'h1122AB44) begin n_fail++; $display("FAIL size3_unchanged: got %h want 1122ab44", rd_d[0]); end
    do_write(4'd7, 'h300, 0, 2, 3, 1);
    n_cmp++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL reserved_bresp: got %b want 10", wr_resp); end
    do_read(4'd8, 'h200, 2, 2, 2);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_r[i] !== 2'b10 || rd_d[i] !== 32'h0)
        begin n_fail++; $display("FAIL wrap_len2_read%0d: got %b/%h want 10/0", i, rd_r[i], rd_d[i]); end
    end
  endtask

  task automatic test_wlast();
    logic [1:0] er;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd2, 'h700, 3, 2, 1, 2);   // early wlast
    model_write('h700, 3, 2, 1, 2, er);
    n_cmp++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL early_wlast_bresp: got %b want 10", wr_resp); end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hD0 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd2, 'h710, 1, 2, 1, 4);   // two beats past len
    model_write('h710, 1, 2, 1, 4, er);
    n_cmp++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL late_wlast_bresp: got %b want 10", wr_resp); end
    do_read(4'd2, 'h700, 1, 2, 1);
    model_read('h700, 1, 2, 1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rd_d[i] !== ex_d[i]) begin n_fail++; $display("FAIL early_wlast_data%0d: got %h want %h", i, rd_d[i], ex_d[i]); end
    end
    do_read(4'd2, 'h710, 1, 2, 1);
    model_read('h710, 1, 2, 1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rd_d[i] !== ex_d[i]) begin n_fail++; $display("FAIL late_wlast_data%0d: got %h want %h", i, rd_d[i], ex_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    int t;
    logic [31:0] held;
    model_read('h200, 0, 2, 1);
    @(negedge clk);
    rready = 0; arvalid = 1; arid = 4'd3; araddr = 32'h200; arlen = 0; arsize = 2; arburst = 1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clk); t++; end
    held = rdata;
    n_cmp++; if (held !== ex_d[0]) begin n_fail++; $display("FAIL bp_rdata: got %h want %h", held, ex_d[0]); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (rvalid !== 1'b1 || rdata !== held || rlast !== 1'b1)
        begin n_fail++; $display("FAIL bp_hold%0d: got v%b %h l%b want v1 %h l1", k, rvalid, rdata, rlast, held); end
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release: rvalid %b want 0", rvalid); end
  endtask

  task automatic test_concurrent();
    logic [1:0] er;
    wd[0] = 32'h55AA55AA; wd[1] = 32'h12345678; ws[0] = 4'hF; ws[1] = 4'hF;
    model_read('h100, 0, 2, 1);
    fork
      do_write(4'hA, 'h600, 1, 2, 1, 2);
      do_read(4'hB, 'h100, 0, 2, 1);
    join
    model_write('h600, 1, 2, 1, 2, er);
    n_cmp++; if (wr_resp !== 2'b00 || wr_id !== 4'hA)
      begin n_fail++; $display("FAIL conc_b: got %b id %h want 00 id a", wr_resp, wr_id); end
    n_cmp++; if (rd_d[0] !== ex_d[0] || rd_id !== 4'hB || rd_r[0] !== 2'b00)
      begin n_fail++; $display("FAIL conc_r: got %h id %h resp %b want %h id b resp 00", rd_d[0], rd_id, rd_r[0], ex_d[0]); end
    do_read(4'd0, 'h600, 1, 2, 1);
    n_cmp++; if (rd_d[0] !== 32'h55AA55AA || rd_d[1] !== 32'h12345678)
      begin n_fail++; $display("FAIL conc_wdata: got %h %h want 55aa55aa 12345678", rd_d[0], rd_d[1]); end
  endtask

  task automatic test_reset_midburst();
    logic [1:0] er;
    wd[0] = 32'h0000_1111; wd[1] = 32'h0000_2222; ws[0] = 4'hF; ws[1] = 4'hF;
    @(negedge clk);
    awvalid = 1; awid = 4'd1; awaddr = 32'h400; awlen = 3; awsize = 2; awburst = 1;
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = 0;
      @(negedge clk);
    end
    wvalid = 0;
    nrst = 0;
    #1;
    n_cmp++; if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0)
      begin n_fail++; $display("FAIL midburst_rst: got aw%b w%b b%b want aw1 w0 b0", awready, wready, bvalid); end
    @(negedge clk);
    nrst = 1;
    model_write('h400, 3, 2, 1, 2, er);
    do_read(4'd1, 'h400, 1, 2, 1);
    model_read('h400, 1, 2, 1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rd_d[i] !== ex_d[i]) begin n_fail++; $display("FAIL midburst_keep%0d: got %h want %h", i, rd_d[i], ex_d[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] er;
    int burst, size, len, nb;
    longint addr;
    // Give the scratch region known contents so narrow writes read back deterministically.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(4'd0, 'h1000 + longint'(blk) * 1024, 255, 2, 1, 256);
      model_write('h1000 + longint'(blk) * 1024, 255, 2, 1, 256, er);
      n_cmp++; if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL fill_bresp%0d: got %b want 00", blk, wr_resp); end
    end
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    burst = 0;
        2, 3, 4, 5: burst = 1;
        9:       burst = 3;
        default: burst = 2;
      endcase
      size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2) begin
        case ($urandom_range(0, 4))
          0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2;
        endcase
      end else len = int'($urandom_range(0, 7));
      addr = 'h1000 + longint'($urandom_range(0, 'hDFF));
      nb = len + 1;
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      do_write(4'(it), addr, len, size, burst, nb);
      model_write(addr, len, size, burst, nb, er);
      n_cmp++; if (wr_resp !== er || wr_id !== 4'(it))
        begin n_fail++; $display("FAIL rnd%0d_b: got %b id %h want %b id %h", it, wr_resp, wr_id, er, 4'(it)); end
      do_read(4'(it + 1), addr, len, size, burst);
      model_read(addr, len, size, burst);
      n_cmp++; if (rd_n !== nb || rd_id !== 4'(it + 1))
        begin n_fail++; $display("FAIL rnd%0d_rcount: got %0d id %h want %0d id %h", it, rd_n, rd_id, nb, 4'(it + 1)); end
      for (int i = 0; i < nb && i < rd_n; i++) begin
        n_cmp++; if (rd_d[i] !== ex_d[i] || rd_r[i] !== ex_r[i] || rd_l[i] !== (i == len))
          begin n_fail++; $display("FAIL rnd%0d_beat%0d: got %h/%b/%b want %h/%b/%b",
                                   it, i, rd_d[i], rd_r[i], rd_l[i], ex_d[i], ex_r[i], i == len); end
      end
    end
  endtask

  initial begin
    clk = 0; nrst = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    awlock = 0; awcache = 0; awprot = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    arlock = 0; arcache = 0; arprot = 0; rready = 0;
    test_reset();
    test_single();
    test_incr4();
    test_wrap();
    test_narrow();
    test_errors();
    test_wlast();
    test_backpressure();
    test_concurrent();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

endmodule
